traffic_light_ctrl: RTL and testbench

- Timed Moore FSM for a T-junction with four signal heads: main road direction 1 (M1), main road direction 2 (M2), main-road turn lane (MT), and side road (S).
- Sequences six phases with fixed, parameterised durations counted in clock cycles. One clock cycle equals one second in the system.
- Standalone top-level controller. No inputs besides clock and reset.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_light_ctrl_if.sv | 16 +
 rtl/tlc_phase_timer.sv | 20 ++
 rtl/traffic_light_ctrl.sv | 104 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings, phase enum and default timings for traffic_light_ctrl
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int T_MAIN_DEF = 7;
  localparam int T_TURN_DEF = 5;
  localparam int T_SIDE_DEF = 3;
  localparam int T_YEL_DEF  = 2;
  localparam int CNT_W_DEF  = 4;

  // Encodings 6 and 7 are unused and treated as corrupted state.
  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      S1:      next_phase = S2;
      S2:      next_phase = S3;
      S3:      next_phase = S4;
      S4:      next_phase = S5;
      S5:      next_phase = S6;
      default: next_phase = S1;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - phase timer handshake and decoded light heads
interface traffic_light_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             load;
  logic [CNT_W-1:0] dur_m1;
  logic             tc;
  logic [2:0]       light_m1;
  logic [2:0]       light_m2;
  logic [2:0]       light_mt;
  logic [2:0]       light_s;

  modport master (output load, dur_m1, light_m1, light_m2, light_mt, light_s, input tc);
  modport slave  (input load, dur_m1, output tc);
  modport mon    (input light_m1, light_m2, light_mt, light_s);
endinterface

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - per-phase cycle counter with terminal-count pulse
module tlc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  traffic_light_ctrl_if.slave tmr
);
  logic [CNT_W-1:0] count;

  assign tmr.tc = (count == tmr.dur_m1);

  always_ff @(posedge clk) begin
    if (!rst || tmr.load) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - six-phase timed Moore controller for a T-junction
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int T_MAIN = T_MAIN_DEF,
  parameter int T_TURN = T_TURN_DEF,
  parameter int T_SIDE = T_SIDE_DEF,
  parameter int T_YEL  = T_YEL_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);
  localparam int T_MAX = (T_MAIN > T_TURN ? (T_MAIN > T_SIDE ? (T_MAIN > T_YEL ? T_MAIN : T_YEL)
                                                           : (T_SIDE > T_YEL ? T_SIDE : T_YEL))
                                          : (T_TURN > T_SIDE ? (T_TURN > T_YEL ? T_TURN : T_YEL)
                                                           : (T_SIDE > T_YEL ? T_SIDE : T_YEL)));

  if (T_MAIN < 1 || T_TURN < 1 || T_SIDE < 1 || T_YEL < 1) begin : g_bad_dur
    $fatal(1, "traffic_light_ctrl: phase durations must be at least one cycle");
  end
  if ((T_MAX - 1) >= (1 << CNT_W)) begin : g_bad_width
    $fatal(1, "traffic_light_ctrl: CNT_W too narrow for the longest phase");
  end

  phase_t phase;
  phase_t phase_nxt;
  logic   legal;

  traffic_light_ctrl_if #(.CNT_W(CNT_W)) tif ();

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .tmr (tif.slave)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= S1;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    legal        = 1'b1;
    tif.dur_m1   = '0;
    tif.light_m1 = RED;
    tif.light_m2 = RED;
    tif.light_mt = RED;
    tif.light_s  = RED;
    case (phase)
      S1: begin
        tif.dur_m1   = CNT_W'(T_MAIN - 1);
        tif.light_m1 = GREEN;
        tif.light_m2 = GREEN;
      end
      S2: begin
        tif.dur_m1   = CNT_W'(T_YEL - 1);
        tif.light_m1 = GREEN;
        tif.light_m2 = YELLOW;
      end
      S3: begin
        tif.dur_m1   = CNT_W'(T_TURN - 1);
        tif.light_m1 = GREEN;
        tif.light_mt = GREEN;
      end
      S4: begin
        tif.dur_m1   = CNT_W'(T_YEL - 1);
        tif.light_m1 = YELLOW;
        tif.light_mt = YELLOW;
      end
      S5: begin
        tif.dur_m1   = CNT_W'(T_SIDE - 1);
        tif.light_s  = GREEN;
      end
      S6: begin
        tif.dur_m1   = CNT_W'(T_YEL - 1);
        tif.light_s  = YELLOW;
      end
      default: legal = 1'b0;
    endcase

    // A corrupted phase restarts the cycle with a fresh count.
    tif.load = tif.tc | ~legal;
    if (!legal) begin
      phase_nxt = S1;
    end else if (tif.tc) begin
      phase_nxt = next_phase(phase);
    end else begin
      phase_nxt = phase;
    end
  end

  assign light_M1 = tif.light_m1;
  assign light_M2 = tif.light_m2;
  assign light_MT = tif.light_mt;
  assign light_S  = tif.light_s;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - scoreboard bench for traffic_light_ctrl, default and short timings
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   inj_a = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_if #(.CNT_W(4)) lif_a ();
  traffic_light_ctrl_if #(.CNT_W(2)) lif_b ();

  traffic_light_ctrl dut_a (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (lif_a.light_m1),
    .light_M2 (lif_a.light_m2),
    .light_MT (lif_a.light_mt),
    .light_S  (lif_a.light_s)
  );

  traffic_light_ctrl #(.T_MAIN(3), .T_TURN(2), .T_SIDE(1), .T_YEL(1), .CNT_W(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (lif_b.light_m1),
    .light_M2 (lif_b.light_m2),
    .light_MT (lif_b.light_mt),
    .light_S  (lif_b.light_s)
  );

  // Expected heads {M1,M2,MT,S} k cycles into the junction's cycle.
  function automatic logic [11:0] exp_lights(input int k, input int tm, input int tt,
                                             input int ts, input int ty);
    int d[6];
    logic [11:0] pat[6];
    int p;
    d = '{tm, ty, tt, ty, ts, ty};
    pat = '{{GREEN, GREEN, RED, RED}, {GREEN, YELLOW, RED, RED}, {GREEN, RED, GREEN, RED},
            {YELLOW, RED, YELLOW, RED}, {RED, RED, RED, GREEN}, {RED, RED, RED, YELLOW}};
    p = k % (tm + tt + ts + 3 * ty);
    exp_lights = {RED, RED, RED, RED};
    for (int i = 0; i < 6; i++) begin
      if (p < d[i]) begin
        exp_lights = pat[i];
        break;
      end
      p -= d[i];
    end
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit safe(input logic [11:0] v);
    bit ok;
    ok = 1'b1;
    for (int h = 0; h < 4; h++) begin
      if (!(v[h*3 +: 3] inside {RED, YELLOW, GREEN})) ok = 1'b0;
    end
    if (v[2:0] != RED && v[11:3] != {RED, RED, RED}) ok = 1'b0;
    if (v[5:3] == GREEN && v[8:6] != RED) ok = 1'b0;
    return ok;
  endfunction

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  bit          brk_q[$];
  int          k_a = 0;
  int          k_b = 0;

  // Reference: cycles elapsed since the last restart determine every head.
  always @(posedge clk) begin
    if (!rst || inj_a) k_a = 0; else k_a = k_a + 1;
    if (!rst) k_b = 0; else k_b = k_b + 1;
    q_a.push_back(exp_lights(k_a, 7, 5, 3, 2));
    q_b.push_back(exp_lights(k_b, 3, 2, 1, 1));
    brk_q.push_back(!rst || inj_a);
  end

  logic [2:0] prev_h[4];
  int         yrun[4];

  always @(posedge clk) begin
    logic [11:0] act_a, act_b, e;
    bit brk;
    #1;
    act_a = {lif_a.light_m1, lif_a.light_m2, lif_a.light_mt, lif_a.light_s};
    act_b = {lif_b.light_m1, lif_b.light_m2, lif_b.light_mt, lif_b.light_s};
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("lights_default", act_a, e);
      e = q_b.pop_front();
      chk("lights_short", act_b, e);
      brk = brk_q.pop_front();
      chk("safety_default", {11'd0, safe(act_a)}, 12'd1);
      chk("safety_short", {11'd0, safe(act_b)}, 12'd1);
      for (int h = 0; h < 4; h++) begin
        logic [2:0] cur;
        cur = act_a[h*3 +: 3];
        if (!brk && cur == RED && prev_h[h] != RED)
          chk("yellow_before_red", {11'd0, prev_h[h] == YELLOW && yrun[h] == 2}, 12'd1);
        if (brk) yrun[h] = 0;
        else if (cur == YELLOW) yrun[h] = (prev_h[h] == YELLOW) ? yrun[h] + 1 : 1;
        prev_h[h] = cur;
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_pattern", {lif_a.light_m1, lif_a.light_m2, lif_a.light_mt, lif_a.light_s},
        {GREEN, GREEN, RED, RED});
    rst = 1'b1;
    repeat (200) @(negedge clk);

    // Abort during the side-road green.
    n = 0;
    while (!((k_a % 21) >= 16 && (k_a % 21) < 19) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("reach_s5", {lif_a.light_m1, lif_a.light_m2, lif_a.light_mt, lif_a.light_s},
        {RED, RED, RED, GREEN});
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    // Corrupt the phase register to an unused encoding.
    force dut_a.phase = phase_t'(3'd6);
    #1;
    chk("illegal_all_red", {lif_a.light_m1, lif_a.light_m2, lif_a.light_mt, lif_a.light_s},
        {RED, RED, RED, RED});
    release dut_a.phase;
    inj_a = 1'b1;
    @(posedge clk);
    #2;
    inj_a = 1'b0;
    repeat (30) @(negedge clk);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
